// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath width and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SLT = 3'd5
  } alu_op_e;

  localparam int unsigned ALU_W = 32;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [2:0] OP_MAX_LEGAL = 3'd5;

endpackage

// File: rtl/alu_issue_q_if.sv
// Command, ALU and response buses of the ALU issue queue.
// ALU_ISSUE_ERR_EN adds the rsp_err response bit.
interface alu_issue_q_if #(
  parameter int unsigned W     = 32,
  parameter int unsigned TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [W-1:0]     cmd_a;
  logic [W-1:0]     cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic [2:0]       alu_op;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [W-1:0]     alu_y;
  logic [3:0]       alu_flags;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_y;
  logic [3:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
`ifdef ALU_ISSUE_ERR_EN
  logic             rsp_err;
`endif

  // Environment side: issues commands, hosts the ALU, consumes responses.
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, alu_y, alu_flags, rsp_ready,
    input  cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_y, rsp_flags, rsp_tag
`ifdef ALU_ISSUE_ERR_EN
    , input rsp_err
`endif
  );

  // Issue-queue side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, alu_y, alu_flags, rsp_ready,
    output cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_y, rsp_flags, rsp_tag
`ifdef ALU_ISSUE_ERR_EN
    , output rsp_err
`endif
  );

endinterface

// File: rtl/alu_issue_fifo.sv
// Synchronous FIFO with head read-through; count distinguishes full from empty.
module alu_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_q.sv
// Issue stage in front of the combinational ALU: command FIFO, ALU drive, response register.
// ALU_ISSUE_ERR_EN: ops above OP_MAX_LEGAL capture zero result/flags and raise rsp_err.
module alu_issue_q
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = ALU_W,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_issue_q_if.slave  bus,
  output logic [CW-1:0] count
);

  localparam int unsigned EW = TAG_W + 3 + 2 * W;

  logic [EW-1:0]    wdata, head;
  logic             full, empty, cmd_ready, push, issue;
  logic [TAG_W-1:0] head_tag;
  logic [2:0]       head_op;
  logic [W-1:0]     head_a, head_b;

  logic             rsp_valid_d, rsp_valid_q;
  logic [W-1:0]     rsp_y_d, rsp_y_q;
  logic [3:0]       rsp_flags_d, rsp_flags_q;
  logic [TAG_W-1:0] rsp_tag_d, rsp_tag_q;
`ifdef ALU_ISSUE_ERR_EN
  logic             rsp_err_d, rsp_err_q;
`endif

  assign wdata = {bus.cmd_tag, bus.cmd_op, bus.cmd_a, bus.cmd_b};
  assign {head_tag, head_op, head_a, head_b} = head;

  // Occupancy-only ready; held low while reset is asserted.
  assign cmd_ready     = !full && !rst;
  assign bus.cmd_ready = cmd_ready;
  assign push          = bus.cmd_valid && cmd_ready;
  assign issue         = !empty && (!rsp_valid_q || bus.rsp_ready);

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (issue),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    bus.alu_op = '0;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    if (!empty) begin
      bus.alu_op = head_op;
      bus.alu_a  = head_a;
      bus.alu_b  = head_b;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    rsp_tag_d   = rsp_tag_q;
`ifdef ALU_ISSUE_ERR_EN
    rsp_err_d   = rsp_err_q;
`endif
    if (issue) begin
      rsp_valid_d = 1'b1;
      rsp_y_d     = bus.alu_y;
      rsp_flags_d = bus.alu_flags;
      rsp_tag_d   = head_tag;
`ifdef ALU_ISSUE_ERR_EN
      rsp_err_d   = 1'b0;
      if (head_op > OP_MAX_LEGAL) begin
        rsp_y_d     = '0;
        rsp_flags_d = '0;
        rsp_err_d   = 1'b1;
      end
`endif
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      rsp_tag_q   <= '0;
`ifdef ALU_ISSUE_ERR_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_tag_q   <= rsp_tag_d;
`ifdef ALU_ISSUE_ERR_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.rsp_tag   = rsp_tag_q;
`ifdef ALU_ISSUE_ERR_EN
  assign bus.rsp_err   = rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_issue_q.sv
// Self-checking bench for alu_issue_q with a behavioural ALU attached to the ALU bus.
module tb_alu_issue_q;
  import alu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned NSTR  = 2000;

  logic       clk;
  logic       rst;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  alu_issue_q_if #(.W(W), .TAG_W(TAG_W)) bus ();

  alu_issue_q #(
    .DEPTH (DEPTH),
    .W     (W),
    .TAG_W (TAG_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU; ops 6/7 produce a recognisable junk pattern.
  function automatic logic [35:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] y;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        {c, y} = {1'b0, a} + {1'b0, b};
        v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      3'd1: begin
        y = a - b;
        c = (a >= b);
        v = (a[31] != b[31]) && (y[31] != a[31]);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = {31'b0, ($signed(a) < $signed(b))};
      default: return {32'hDEAD_BEEF, 4'hF};
    endcase
    return {y, (y == 32'b0), y[31], c, v};
  endfunction

  always_comb {bus.alu_y, bus.alu_flags} = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp_y;
    logic [3:0]  exp_flags;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  // Scoreboard for the streaming phase: {tag, y, flags}.
  logic [39:0] sb_q[$];
  bit          sb_en    = 1'b0;
  int          n_pushed = 0;
  int          n_rsp    = 0;

  always @(negedge clk) begin
    if (sb_en) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("stream_unexpected_rsp", 64'(bus.rsp_tag), 64'hFFFF);
        end else begin
          check("stream_rsp", 64'({bus.rsp_tag, bus.rsp_y, bus.rsp_flags}),
                64'(sb_q.pop_front()));
        end
        n_rsp++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        sb_q.push_back({bus.cmd_tag, alu_model(bus.cmd_op, bus.cmd_a, bus.cmd_b)});
        n_pushed++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int accepted;
    int stale;
    int cyc;

    vecs[0] = '{3'd0, 32'd2,          32'd3,          4'd1, 32'd5,          4'b0000, 1'b0};
    vecs[1] = '{3'd1, 32'd7,          32'd7,          4'd2, 32'd0,          4'b1010, 1'b0};
    vecs[2] = '{3'd5, 32'hFFFF_FFFF,  32'd1,          4'd3, 32'd1,          4'b0000, 1'b0};
    vecs[3] = '{3'd2, 32'hF0F0_0000,  32'hFF00_0000,  4'd4, 32'hF000_0000,  4'b0100, 1'b0};
    vecs[4] = '{3'd3, 32'h0000_000F,  32'h0000_00F0,  4'd5, 32'h0000_00FF,  4'b0000, 1'b0};
    vecs[5] = '{3'd4, 32'hA5A5_A5A5,  32'hA5A5_A5A5,  4'd6, 32'd0,          4'b1000, 1'b0};
    vecs[6] = '{3'd0, 32'hFFFF_FFFF,  32'd1,          4'd7, 32'd0,          4'b1010, 1'b0};
    vecs[7] = '{3'd0, 32'h7FFF_FFFF,  32'd1,          4'd8, 32'h8000_0000,  4'b0101, 1'b0};
`ifdef ALU_ISSUE_ERR_EN
    vecs[8] = '{3'd7, 32'd1,          32'd1,          4'd9, 32'd0,          4'b0000, 1'b1};
`else
    vecs[8] = '{3'd7, 32'd1,          32'd1,          4'd9, 32'hDEAD_BEEF,  4'b1111, 1'b0};
`endif
    vecs[9] = '{3'd0, 32'd1,          32'd1,          4'hA, 32'd2,          4'b0000, 1'b0};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b1;

    #2;
    check("reset_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    #10;
    rst = 1'b0;
    #1;
    check("post_reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("post_reset_rsp_data", 64'({bus.rsp_y, bus.rsp_flags, bus.rsp_tag}), 64'd0);
    check("post_reset_alu_drive", 64'({bus.alu_op, bus.alu_a, bus.alu_b}), 64'd0);
    tick();

    // Single commands into an empty queue: response appears one edge after acceptance.
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = vecs[i].op;
      bus.cmd_a     = vecs[i].a;
      bus.cmd_b     = vecs[i].b;
      bus.cmd_tag   = vecs[i].tag;
      tick();
      bus.cmd_valid = 1'b0;
      check($sformatf("v%0d_no_bypass", i), 64'(bus.rsp_valid), 64'd0);
      check($sformatf("v%0d_count", i), 64'(count), 64'd1);
      check($sformatf("v%0d_alu_op", i), 64'(bus.alu_op), 64'(vecs[i].op));
      tick();
      check($sformatf("v%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'd1);
      check($sformatf("v%0d_rsp_y", i), 64'(bus.rsp_y), 64'(vecs[i].exp_y));
      check($sformatf("v%0d_rsp_flags", i), 64'(bus.rsp_flags), 64'(vecs[i].exp_flags));
      check($sformatf("v%0d_rsp_tag", i), 64'(bus.rsp_tag), 64'(vecs[i].tag));
`ifdef ALU_ISSUE_ERR_EN
      check($sformatf("v%0d_rsp_err", i), 64'(bus.rsp_err), 64'(vecs[i].exp_err));
`endif
      tick();
      check($sformatf("v%0d_drained", i), 64'(bus.rsp_valid), 64'd0);
    end

    // Backpressure: 4 FIFO entries plus the response register absorb 5 of 6 commands.
    bus.rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd0;
      bus.cmd_a     = 32'(i);
      bus.cmd_b     = 32'd10;
      bus.cmd_tag   = 4'(i);
      if (bus.cmd_ready) accepted++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("bp_accepted", 64'(accepted), 64'd5);
    check("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("bp_count", 64'(count), 64'd4);
    tick();
    tick();
    check("bp_rsp_stable", 64'({bus.rsp_valid, bus.rsp_tag, bus.rsp_y}), {31'd0, 1'b1, 4'd0, 32'd10});
    check("bp_head_on_alu", 64'(bus.alu_a), 64'd1);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_out%0d", k), 64'({bus.rsp_valid, bus.rsp_tag, bus.rsp_y}),
            {31'd0, 1'b1, 4'(k), 32'(k + 10)});
      tick();
      if (k == 0) check("bp_ready_after_pop", 64'(bus.cmd_ready), 64'd1);
    end
    check("bp_empty_after", 64'({bus.rsp_valid, count}), 64'd0);

    // Reset asserted between edges with 3 queued and one response held.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd1;
      bus.cmd_a     = 32'(i + 5);
      bus.cmd_b     = 32'd1;
      bus.cmd_tag   = 4'(i + 3);
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("mid_pre_count", 64'(count), 64'd3);
    check("mid_pre_valid", 64'(bus.rsp_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_count", 64'(count), 64'd0);
    check("mid_alu_drive", 64'({bus.alu_op, bus.alu_a, bus.alu_b}), 64'd0);
    check("mid_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.rsp_valid) stale++;
    end
    check("mid_no_stale", 64'(stale), 64'd0);
    check("mid_ready_back", 64'(bus.cmd_ready), 64'd1);

    // Random streaming against the scoreboard.
    sb_en = 1'b1;
    cyc = 0;
    while (n_pushed < NSTR && cyc < 20000) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      bus.cmd_valid = ($urandom_range(0, 3) != 0);
      bus.cmd_op    = 3'($urandom_range(0, 5));
      bus.cmd_b     = $urandom;
      bus.cmd_a     = ($urandom_range(0, 3) == 0) ? bus.cmd_b : $urandom;
      bus.cmd_tag   = 4'(n_pushed);
      tick();
      cyc++;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    cyc = 0;
    while ((sb_q.size() != 0 || bus.rsp_valid) && cyc < 100) begin
      tick();
      cyc++;
    end
    sb_en = 1'b0;
    check("stream_pushed", 64'(n_pushed), 64'(NSTR));
    check("stream_received", 64'(n_rsp), 64'(NSTR));
    check("stream_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_q.md
Name: alu_issue_q

Overview:
- Command-issue stage directly upstream of the combinational ALU (`alu`: op[2:0], a, b -> y, z, n, c, v).
- Accepts tagged commands over a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Drives the FIFO head onto the ALU inputs, captures the ALU result and flags into a single response register, and presents that register over a valid/ready response interface.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- W, 32, operand/result width; must match the ALU.
- TAG_W, 4, width of the opaque command tag carried to the response.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  3  ALU opcode (alu_pkg::alu_op_e).
- cmd_a  in  W  operand A.
- cmd_b  in  W  operand B.
- cmd_tag  in  TAG_W  command tag.
- alu_op  out  3  to ALU op.
- alu_a  out  W  to ALU a.
- alu_b  out  W  to ALU b.
- alu_y  in  W  from ALU y.
- alu_flags  in  4  from ALU {z,n,c,v}.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_y  out  W  captured result.
- rsp_flags  out  4  captured {z,n,c,v}.
- rsp_tag  out  TAG_W  tag of the captured command.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert by rst release):
  - FIFO emptied; count=0.
  - cmd_ready=1 after reset; cmd_ready=0 while rst is high.
  - rsp_valid=0; rsp_y=0, rsp_flags=0, rsp_tag=0.
- Reset mid-operation discards all queued and captured commands; there is no replay.
- Push: cmd_valid && cmd_ready at a rising edge writes the entry to the tail.
- cmd_ready = (count < DEPTH). It is a registered/occupancy-derived signal only, with no combinational path from rsp_ready.
- ALU drive:
  - When count>0, alu_op/alu_a/alu_b equal the head entry.
  - When empty, they are 0/0/0.
  - The ALU is combinational, so its result is consumed in the same cycle.
- Issue condition: head_valid && (!rsp_valid || rsp_ready).
- On issue at a rising edge:
  - rsp_y <= alu_y, rsp_flags <= alu_flags, rsp_tag <= head tag, rsp_valid <= 1.
  - The head is popped.
- If the response is taken (rsp_valid && rsp_ready) with no issue, rsp_valid <= 0 and the data fields hold their values.
- Latency: a command accepted at edge N into an empty FIFO appears on rsp_* after edge N+1. There is no push-to-head bypass.
- Throughput: one command per cycle sustained when rsp_ready=1.
- Full FIFO with a simultaneous pop: a push is refused that cycle (cmd_ready=0). count decrements, and cmd_ready rises the next cycle.
- Empty FIFO with a simultaneous push: no issue that cycle. count becomes 1.
- Simultaneous push and pop when not full: count unchanged; ordering is strictly FIFO.
- Backpressure: while rsp_ready=0 and rsp_valid=1, rsp_* stay stable and the head stays on the ALU inputs.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Opcodes 0..5 are passed through unchanged. Opcodes 6/7 are handled as described under Optional Feature.

Optional Feature:
- Macro: ALU_ISSUE_ERR_EN.
- Defined:
  - Adds output rsp_err (1 bit, reset 0).
  - An issued command with op >= 6 captures rsp_y=0, rsp_flags=0, rsp_err=1, while the ALU still sees the op.
  - Legal ops capture rsp_err=0.
- Undefined:
  - No rsp_err port.
  - Ops 6/7 are issued and captured like any other op, whatever the ALU produces.

Decomposition:
- alu_pkg holds:
  - alu_op_e: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5.
  - ALU_W=32.
  - Flag index constants FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
  - OP_MAX_LEGAL=5.
- One sub-module: alu_issue_fifo, a synchronous FIFO parameterised by DEPTH and width, with push/pop/full/empty/count and head read-through.
- Response register and issue logic live in alu_issue_q.

Test Plan:
- Single command: op=ADD, a=2, b=3, tag=1, rsp_ready=1 -> after edge N+1, rsp_valid=1, rsp_y=5, rsp_tag=1, rsp_flags[Z]=0.
- SUB zero flag: op=SUB, a=7, b=7 -> rsp_y=0, rsp_flags[Z]=1. SLT: a=32'hFFFF_FFFF, b=1 -> rsp_y=1.
- Backpressure/full: hold rsp_ready=0 and push 6 commands (tags 0..5) -> 5 accepted (4 FIFO + 1 response register), cmd_ready=0, count=4, rsp_tag=0 stable. Release rsp_ready -> tags 0..4 emerge in order, one per cycle.
- Reset mid-stream: 3 queued plus rsp_valid=1, assert rst asynchronously between edges -> rsp_valid=0, count=0, and alu_op/a/b=0 immediately. No stale response appears after release.
- Streaming: 2000 random legal commands with random rsp_ready -> every response matches a reference model of ADD/SUB/AND/OR/XOR/SLT, tags arrive in order, with no loss or duplication.
- ALU_ISSUE_ERR_EN build: op=7, a=1, b=1 -> rsp_err=1, rsp_y=0, rsp_flags=0. The next op=ADD -> rsp_err=0.
